// File: rtl/my_softcore_dbg_pkg.sv
// ---------------------------------------------------------------------------
// my_softcore_dbg_pkg
// Shared definitions for the debug memory controller:
//   - FSM state encoding
//   - bit positions of the fields carried on the 38-bit jdo bus
//   - strobe vector layout and priority (higher index wins)
// Optional feature macro used by the importing files: MY_SOFTCORE_DBG_MEM_TIMEOUT_EN
// ---------------------------------------------------------------------------
package my_softcore_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } dbg_state_e;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RDFLAG    = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  // Strobes are packed into one vector; when several arrive together the
  // highest index is served and the rest are dropped.
  localparam int STB_NO_ACT_A = 0;
  localparam int STB_ACT_B    = 1;
  localparam int STB_ACT_A    = 2;
  localparam int STB_W        = 3;

  function automatic logic multi_strobe(input logic [STB_W-1:0] stb);
    return ($countones(stb) > 1);
  endfunction

endpackage

// File: rtl/my_softcore_cpu_cpu_debug_mem_timer.sv
// ---------------------------------------------------------------------------
// my_softcore_cpu_cpu_debug_mem_timer
// Waitrequest timeout counter for the debug memory controller. Only built
// when MY_SOFTCORE_DBG_MEM_TIMEOUT_EN is defined.
// Ports:
//   clk        in  system clock
//   reset_n    in  async active-low reset
//   clear_i    in  clears the count (asserted on every access launch)
//   wait_i     in  an access is outstanding and the slave stalls this cycle
//   timeout_o  out this stalled cycle is the TIMEOUT_CYC-th one: abort now
// ---------------------------------------------------------------------------
`ifdef MY_SOFTCORE_DBG_MEM_TIMEOUT_EN
module my_softcore_cpu_cpu_debug_mem_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Abort on the stalled cycle that brings the count to TIMEOUT_CYC, so the
  // request is visible for exactly TIMEOUT_CYC stalled cycles.
  assign timeout_o = wait_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/my_softcore_cpu_cpu_debug_mem_ctrl.sv
// ---------------------------------------------------------------------------
// my_softcore_cpu_cpu_debug_mem_ctrl
// Turns the JTAG debug slave's sysclk strobes into single-word Avalon-MM
// reads/writes and reports data/status back to the debug slave.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   jdo[37:0]                        addr/rd_flag/wdata fields from debug slave
//   take_action_ocimem_a             load address, optionally read
//   take_no_action_ocimem_a          read at current address
//   take_action_ocimem_b             write jdo data at current address
//   avm_address/read/write/writedata Avalon master request
//   avm_readdata, avm_waitrequest    Avalon slave response
//   MonDReg                          last read data
//   monitor_ready                    idle, last access complete
//   monitor_error                    sticky error (collision / timeout)
// Optional feature: MY_SOFTCORE_DBG_MEM_TIMEOUT_EN adds a waitrequest
// timeout of TIMEOUT_CYC stalled cycles.
// ---------------------------------------------------------------------------
module my_softcore_cpu_cpu_debug_mem_ctrl
  import my_softcore_dbg_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  dbg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mon_addr_q, mon_addr_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [STB_W-1:0]  stb;
  logic              launch;
  logic              timeout;
  logic              multi;
  logic              unused_jdo;

  // Not every jdo bit is a field for this block.
  assign unused_jdo = ^jdo;

  assign stb[STB_ACT_A]    = take_action_ocimem_a;
  assign stb[STB_ACT_B]    = take_action_ocimem_b;
  assign stb[STB_NO_ACT_A] = take_no_action_ocimem_a;
  assign multi             = multi_strobe(stb);

`ifdef MY_SOFTCORE_DBG_MEM_TIMEOUT_EN
  my_softcore_cpu_cpu_debug_mem_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (launch),
    .wait_i    ((state_q != ST_IDLE) && avm_waitrequest),
    .timeout_o (timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mon_addr_d = mon_addr_q;
    mon_dreg_d = mon_dreg_q;
    wdata_d    = wdata_q;
    ready_d    = ready_q;
    error_d    = error_q;
    launch     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (multi) begin
          error_d = 1'b1;
        end
        if (stb[STB_ACT_A]) begin
          mon_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          // A fresh address clears the error unless this very cycle collided.
          if (!multi) begin
            error_d = 1'b0;
          end
          if (jdo[JDO_RDFLAG]) begin
            state_d = ST_RD;
            ready_d = 1'b0;
            launch  = 1'b1;
          end else begin
            ready_d = 1'b1;
          end
        end else if (stb[STB_ACT_B]) begin
          wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          state_d = ST_WR;
          ready_d = 1'b0;
          launch  = 1'b1;
        end else if (stb[STB_NO_ACT_A]) begin
          state_d = ST_RD;
          ready_d = 1'b0;
          launch  = 1'b1;
        end
      end

      ST_RD, ST_WR: begin
        // Strobes during an access are dropped but flagged.
        if (|stb) begin
          error_d = 1'b1;
        end
        if (timeout) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          error_d = 1'b1;
        end else if (!avm_waitrequest) begin
          if (state_q == ST_RD) begin
            mon_dreg_d = avm_readdata;
          end
          mon_addr_d = mon_addr_q + ADDR_W'(1);
          state_d    = ST_IDLE;
          ready_d    = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mon_addr_q <= '0;
      mon_dreg_q <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_addr_q <= mon_addr_d;
      mon_dreg_q <= mon_dreg_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  // Requests decode straight from the state register so an async reset
  // withdraws them in the same cycle.
  assign avm_read      = (state_q == ST_RD);
  assign avm_write     = (state_q == ST_WR);
  assign avm_address   = {mon_addr_q, 2'b00};
  assign avm_writedata = wdata_q;
  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_my_softcore_cpu_cpu_debug_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_my_softcore_cpu_cpu_debug_mem_ctrl
// Self-checking bench: expected completion results are queued when each
// access is launched and compared when the controller reports ready.
// The timeout scenario is exercised only when MY_SOFTCORE_DBG_MEM_TIMEOUT_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_my_softcore_cpu_cpu_debug_mem_ctrl;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  typedef struct {
    logic [31:0]       dreg;
    logic [ADDR_W+1:0] addr;
    logic              err;
  } exp_t;

  exp_t sb_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  my_softcore_cpu_cpu_debug_mem_ctrl #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [37:0] rd_jdo(input logic [ADDR_W-1:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[17 +: ADDR_W] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] wr_jdo(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Drive strobes for one cycle from a negedge; returns at the following
  // negedge, where the launched request (if any) is visible.
  task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    jdo                     = j;
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo                     = '0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [ADDR_W+1:0] a, input logic e);
    exp_t x;
    x.dreg = d;
    x.addr = a;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  task automatic wait_done(input string tag);
    exp_t x;
    int   n;
    n = 0;
    while (!(monitor_ready && !avm_read && !avm_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_completed"}, 64'(n < 50), 64'(1));
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      x = sb_q.pop_front();
      check_val({tag, "_MonDReg"}, 64'(MonDReg), 64'(x.dreg));
      check_val({tag, "_avm_address"}, 64'(avm_address), 64'(x.addr));
      check_val({tag, "_error"}, 64'(monitor_error), 64'(x.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    avm_readdata            = '0;
    avm_waitrequest         = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_read",      64'(avm_read),      64'(0));
    check_val("rst_write",     64'(avm_write),     64'(0));
    check_val("rst_wdata",     64'(avm_writedata), 64'(0));
    check_val("rst_address",   64'(avm_address),   64'(0));
    check_val("rst_MonDReg",   64'(MonDReg),       64'(0));
    check_val("rst_ready",     64'(monitor_ready), 64'(0));
    check_val("rst_error",     64'(monitor_error), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset asserted while a read is stalled.
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'h1111_2222;
    strobe(1'b1, 1'b0, 1'b0, rd_jdo(9'h055, 1'b1));
    check_val("t1_read_up", 64'(avm_read), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check_val("t1_read_drop", 64'(avm_read),    64'(0));
    check_val("t1_address",   64'(avm_address), 64'(0));
    check_val("t1_ready",     64'(monitor_ready), 64'(0));
    check_val("t1_MonDReg",   64'(MonDReg),     64'(0));
    @(negedge clk);
    reset_n         = 1'b1;
    avm_waitrequest = 1'b0;
    @(negedge clk);

    // 2: zero-wait read.
    avm_readdata = 32'hCAFE_F00D;
    push_exp(32'hCAFE_F00D, 11'h044, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, rd_jdo(9'h010, 1'b1));
    check_val("t2_addr_n1", 64'(avm_address), 64'(11'h040));
    check_val("t2_read_n1", 64'(avm_read), 64'(1));
    check_val("t2_ready_n1", 64'(monitor_ready), 64'(0));
    wait_done("t2");

    // 3: load address 0x1FF without reading, then write with 3 wait cycles.
    push_exp(32'hCAFE_F00D, 11'h7FC, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, rd_jdo(9'h1FF, 1'b0));
    wait_done("t3_load");
    avm_waitrequest = 1'b1;
    push_exp(32'hCAFE_F00D, 11'h000, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, wr_jdo(32'h1234_5678));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (avm_write) begin
        cnt++;
        check_val("t3_wdata", 64'(avm_writedata), 64'(32'h1234_5678));
        avm_waitrequest = (cnt < 4);
        @(negedge clk);
      end else begin
        break;
      end
    end
    check_val("t3_write_cycles", 64'(cnt), 64'(4));
    avm_waitrequest = 1'b0;
    wait_done("t3_write");

    // 4: strobe during an outstanding read, then error cleared by action_a.
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'h0BAD_BEEF;
    push_exp(32'h0BAD_BEEF, 11'h084, 1'b1);
    strobe(1'b1, 1'b0, 1'b0, rd_jdo(9'h020, 1'b1));
    strobe(1'b0, 1'b1, 1'b0, '0);
    check_val("t4_error_set", 64'(monitor_error), 64'(1));
    check_val("t4_still_read", 64'(avm_read), 64'(1));
    check_val("t4_addr_held", 64'(avm_address), 64'(11'h080));
    avm_waitrequest = 1'b0;
    wait_done("t4_read");
    push_exp(32'h0BAD_BEEF, 11'h0C0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, rd_jdo(9'h030, 1'b0));
    wait_done("t4_clear");

    // 6: simultaneous strobes at IDLE.
    push_exp(32'h0BAD_BEEF, 11'h100, 1'b1);
    strobe(1'b1, 1'b0, 1'b1, rd_jdo(9'h040, 1'b0));
    check_val("t6_no_write", 64'(avm_write), 64'(0));
    wait_done("t6_a_b");
    push_exp(32'h0BAD_BEEF, 11'h104, 1'b1);
    strobe(1'b0, 1'b1, 1'b1, wr_jdo(32'hA5A5_0001));
    check_val("t6_b_wins", 64'(avm_write), 64'(1));
    check_val("t6_b_wdata", 64'(avm_writedata), 64'(32'hA5A5_0001));
    wait_done("t6_b_na");
    // read-next leaves the sticky error alone
    avm_readdata = 32'h1357_9BDF;
    push_exp(32'h1357_9BDF, 11'h108, 1'b1);
    strobe(1'b0, 1'b1, 1'b0, '0);
    wait_done("t6_read_next");

`ifdef MY_SOFTCORE_DBG_MEM_TIMEOUT_EN
    // 5: slave never releases waitrequest.
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'hDEAD_DEAD;
    push_exp(32'h1357_9BDF, 11'h1C0, 1'b1);
    strobe(1'b1, 1'b0, 1'b0, rd_jdo(9'h070, 1'b1));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (avm_read) begin
        cnt++;
        @(negedge clk);
      end else begin
        break;
      end
    end
    check_val("t5_read_cycles", 64'(cnt), 64'(4));
    check_val("t5_ready", 64'(monitor_ready), 64'(1));
    wait_done("t5_timeout");
    avm_waitrequest = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
